// File: rtl/mips_pkg.sv
// Shared types and default widths for the data-memory arbiter and its helpers.
package mips_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } arb_state_t;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

endpackage

// File: rtl/dmem_wait_counter.sv
// Saturating count of consecutive cycles a pending debug request was denied.
module dmem_wait_counter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (inc && !at_max) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign at_max = (r_cnt == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the core (priority) and a debug/loader port,
// with a starvation-forced debug slot and a halt mode giving debug exclusive access.
module dmem_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_A,
    input  logic [DATA_W-1:0] cpu_WD,
    input  logic              cpu_WE,
    input  logic              cpu_RE,
    output logic [DATA_W-1:0] cpu_RD,
    output logic              cpu_stall,
    input  logic              dbg_valid,
    output logic              dbg_ready,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_A,
    input  logic [DATA_W-1:0] dbg_WD,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_RD,
    input  logic              dbg_halt,
    output logic              halted,
    output logic [ADDR_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_WD,
    output logic              mem_WE,
    input  logic [DATA_W-1:0] mem_RD
);

    arb_state_t r_state;
    arb_state_t w_state_next;

    logic w_cpu_acc;
    logic w_grant_dbg;
    logic w_grant_cpu;
    logic w_at_max;
    logic w_cnt_inc;
    logic w_cnt_clr;

    assign w_cpu_acc = cpu_WE | cpu_RE;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant is forced off while reset is high so nothing is accepted or written.
    always_comb begin
        w_state_next = r_state;
        w_grant_dbg  = 1'b0;
        w_grant_cpu  = 1'b0;
        w_cnt_inc    = 1'b0;
        w_cnt_clr    = 1'b1;
        case (r_state)
            ST_RUN: begin
                w_grant_dbg = !reset && dbg_valid && (!w_cpu_acc || w_at_max);
                w_grant_cpu = !reset && !w_grant_dbg;
                w_cnt_inc   = dbg_valid && !w_grant_dbg;
                w_cnt_clr   = w_grant_dbg || !dbg_valid || dbg_halt;
                if (dbg_halt) begin
                    w_state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                w_grant_dbg = !reset && dbg_valid;
                if (!dbg_halt) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    dmem_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk    (CLK),
        .reset  (reset),
        .inc    (w_cnt_inc),
        .clr    (w_cnt_clr),
        .at_max (w_at_max)
    );

    assign dbg_ready = w_grant_dbg;
    assign cpu_stall = (w_cpu_acc && w_grant_dbg) || (r_state == ST_HALTED);
    assign halted    = (r_state == ST_HALTED);

    assign mem_A  = w_grant_dbg ? dbg_A  : cpu_A;
    assign mem_WD = w_grant_dbg ? dbg_WD : cpu_WD;
    assign mem_WE = (cpu_WE && w_grant_cpu) || (dbg_we && w_grant_dbg);
    assign cpu_RD = mem_RD;

    always_ff @(posedge CLK) begin
        if (reset) begin
            dbg_rvalid <= 1'b0;
            dbg_RD     <= '0;
        end else if (w_grant_dbg && !dbg_we) begin
            dbg_rvalid <= 1'b1;
            dbg_RD     <= mem_RD;
        end else begin
            dbg_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter against a cycle-level reference model.
module tb_dmem_arbiter;

    localparam int unsigned MW = 4;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cpu_A = '0, cpu_WD = '0;
    logic        cpu_WE = 1'b0, cpu_RE = 1'b0;
    logic [31:0] cpu_RD;
    logic        cpu_stall;
    logic        dbg_valid = 1'b0, dbg_we = 1'b0, dbg_halt = 1'b0;
    logic        dbg_ready, dbg_rvalid, halted;
    logic [31:0] dbg_A = '0, dbg_WD = '0, dbg_RD;
    logic [31:0] mem_A, mem_WD, mem_RD;
    logic        mem_WE;

    logic [31:0] env_mem [0:63];
    logic [31:0] ref_mem [0:63];

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    logic [31:0] exp_q[$];

    bit          m_halted = 1'b0;
    int unsigned m_wait = 0;

    always #5 CLK = ~CLK;

    dmem_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (MW)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .cpu_A      (cpu_A),
        .cpu_WD     (cpu_WD),
        .cpu_WE     (cpu_WE),
        .cpu_RE     (cpu_RE),
        .cpu_RD     (cpu_RD),
        .cpu_stall  (cpu_stall),
        .dbg_valid  (dbg_valid),
        .dbg_ready  (dbg_ready),
        .dbg_we     (dbg_we),
        .dbg_A      (dbg_A),
        .dbg_WD     (dbg_WD),
        .dbg_rvalid (dbg_rvalid),
        .dbg_RD     (dbg_RD),
        .dbg_halt   (dbg_halt),
        .halted     (halted),
        .mem_A      (mem_A),
        .mem_WD     (mem_WD),
        .mem_WE     (mem_WE),
        .mem_RD     (mem_RD)
    );

    // Environment data memory: async read, write at the clock edge.
    assign mem_RD = env_mem[mem_A[7:2]];
    always @(posedge CLK) begin
        if (mem_WE === 1'b1) env_mem[mem_A[7:2]] <= mem_WD;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: every read-data pulse must match the oldest accepted read.
    always @(negedge CLK) begin
        if (dbg_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rvalid_spurious", 32'(dbg_rvalid), 32'd0);
            end else begin
                chk("dbg_RD", dbg_RD, exp_q.pop_front());
            end
        end
    end

    function automatic logic [31:0] rnd_addr();
        logic [2:0] w;
        w = 3'($urandom_range(0, 7));
        return {27'd0, w, 2'b00};
    endfunction

    task automatic step(input bit rst, input bit cwe, input bit cre, input logic [31:0] ca,
                        input logic [31:0] cwd, input bit dv, input bit dwe,
                        input logic [31:0] da, input logic [31:0] dwd, input bit dh);
        bit          acc, g, exp_we, exp_stall;
        logic [31:0] exp_a;
        @(negedge CLK);
        reset = rst; cpu_WE = cwe; cpu_RE = cre; cpu_A = ca; cpu_WD = cwd;
        dbg_valid = dv; dbg_we = dwe; dbg_A = da; dbg_WD = dwd; dbg_halt = dh;
        #1;
        chk("halted", 32'(halted), 32'(m_halted));
        if (rst) begin
            chk("rst_ready", 32'(dbg_ready), 32'd0);
            chk("rst_mem_WE", 32'(mem_WE), 32'd0);
            m_halted = 1'b0;
            m_wait   = 0;
        end else begin
            acc       = cwe || cre;
            g         = dv && (m_halted || !acc || m_wait == MW);
            exp_stall = (acc && g) || m_halted;
            exp_we    = g ? dwe : (cwe && !m_halted);
            exp_a     = g ? da : ca;
            chk("dbg_ready", 32'(dbg_ready), 32'(g));
            chk("cpu_stall", 32'(cpu_stall), 32'(exp_stall));
            chk("mem_WE", 32'(mem_WE), 32'(exp_we));
            chk("mem_A", mem_A, exp_a);
            chk("cpu_RD", cpu_RD, ref_mem[exp_a[7:2]]);
            if (exp_we) chk("mem_WD", mem_WD, g ? dwd : cwd);
            if (g && !dwe) exp_q.push_back(ref_mem[da[7:2]]);
            if (exp_we) ref_mem[exp_a[7:2]] = g ? dwd : cwd;
            if (m_halted || !dv || g || dh) m_wait = 0;
            else if (m_wait < MW) m_wait++;
            m_halted = dh;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            env_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end

        // Reset with a debug write pending: nothing accepted or written.
        step(1, 0, 0, 32'h0, 32'h0, 1, 1, 32'h10, 32'hDEAD0000, 0);
        step(1, 0, 0, 32'h0, 32'h0, 1, 1, 32'h10, 32'hDEAD0000, 0);
        idle();
        chk("post_rst_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("post_rst_dbg_RD", dbg_RD, 32'd0);

        // Debug write then read-back with the core idle.
        step(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h10, 32'hCAFE0001, 0);
        idle();
        step(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0, 0);
        idle();
        idle();

        // Core stores every cycle while a debug read waits: forced slot on the 5th cycle.
        for (int i = 0; i < 7; i++)
            step(0, 1, 0, 32'h14, 32'h100 + 32'(i), 1, 0, 32'h10, 32'h0, 0);
        idle();

        // Core load collides with debug at wait count 1: core wins, no stall.
        step(0, 1, 0, 32'h18, 32'h5A5A5A5A, 1, 0, 32'h10, 32'h0, 0);
        step(0, 0, 1, 32'h18, 32'h0, 1, 0, 32'h10, 32'h0, 0);
        idle();

        // Halt: debug reads back-to-back while core requests are ignored.
        step(0, 1, 0, 32'h1C, 32'h77, 1, 0, 32'h14, 32'h0, 1);
        for (int i = 0; i < 5; i++)
            step(0, 1, 1, 32'h1C, 32'h88, 1, 0, 32'(i) << 2, 32'h0, 1);
        step(0, 1, 0, 32'h1C, 32'h99, 0, 0, 32'h0, 32'h0, 0);
        step(0, 1, 0, 32'h1C, 32'h99, 1, 0, 32'h10, 32'h0, 0);
        idle();

        // Reset while halted with a debug read in flight.
        step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0, 1);
        step(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0, 1);
        idle();
        chk("rst_halt_rvalid", 32'(dbg_rvalid), 32'd0);

        // Randomized traffic.
        begin
            bit dh_r = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 99) < 3) dh_r = !dh_r;
                step($urandom_range(0, 199) == 0,
                     $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                     rnd_addr(), $urandom(),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                     rnd_addr(), $urandom(), dh_r);
            end
        end

        idle();
        idle();
        idle();
        chk("resp_queue_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 8; i++)
            chk("mem_contents", env_mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
